// File: rtl/train_ctrl.sv
// Training-run sequencer: fetches samples, drives them into the cost array,
// accumulates a saturated batch cost and issues weight-update strobes per batch.
module train_ctrl #(
    parameter int unsigned N_IN     = 2,
    parameter int unsigned N_OUT    = 2,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned BATCH    = 4,
    parameter int unsigned N_EPOCH  = 8,
    parameter int unsigned PIPE_LAT = 4,
    localparam int unsigned IDX_W   = (BATCH > 1) ? $clog2(BATCH) : 1,
    localparam int unsigned EP_W    = (N_EPOCH > 1) ? $clog2(N_EPOCH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     smp_req,
    output logic [IDX_W-1:0]         smp_idx,
    input  logic                     smp_vld,
    input  logic [N_IN*WIDTH-1:0]    smp_k,
    input  logic [N_OUT*WIDTH-1:0]   smp_t,
    output logic [N_IN*WIDTH-1:0]    o_k,
    output logic [N_OUT*WIDTH-1:0]   o_t,
    output logic                     load,
    output logic                     accu,
    output logic                     rst_btch,
    output logic                     wr,
    input  logic [WIDTH-1:0]         i_cost,
    output logic [EP_W-1:0]          epoch,
    output logic [WIDTH-1:0]         cost_sum
);

    localparam int unsigned CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        FETCH = 3'd2,
        LOAD  = 3'd3,
        WAIT  = 3'd4,
        ACCU  = 3'd5,
        UPD   = 3'd6,
        FIN   = 3'd7
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] sum_sat;

    // Signed add with one guard bit; clamp when the guard and sign bits disagree.
    always_comb begin
        sum_ext = {cost_sum[WIDTH-1], cost_sum} + {i_cost[WIDTH-1], i_cost};
        sum_sat = sum_ext[WIDTH-1:0];
        if (sum_ext[WIDTH] != sum_ext[WIDTH-1]) begin
            sum_sat = sum_ext[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    // Sequencer; each strobe is set on entry to its state so it is registered and one cycle wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            smp_req  <= 1'b0;
            smp_idx  <= '0;
            o_k      <= '0;
            o_t      <= '0;
            load     <= 1'b0;
            accu     <= 1'b0;
            rst_btch <= 1'b0;
            wr       <= 1'b0;
            epoch    <= '0;
            cost_sum <= '0;
            wait_cnt <= '0;
        end else begin
            load     <= 1'b0;
            accu     <= 1'b0;
            rst_btch <= 1'b0;
            wr       <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CLR;
                        busy     <= 1'b1;
                        epoch    <= '0;
                        smp_idx  <= '0;
                        rst_btch <= 1'b1;
                    end
                end
                CLR: begin
                    cost_sum <= '0;
                    smp_req  <= 1'b1;
                    state    <= FETCH;
                end
                FETCH: begin
                    if (smp_vld) begin
                        o_k     <= smp_k;
                        o_t     <= smp_t;
                        smp_req <= 1'b0;
                        load    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    wait_cnt <= CNT_W'(PIPE_LAT - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        accu  <= 1'b1;
                        state <= ACCU;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                ACCU: begin
                    cost_sum <= sum_sat;
                    if (smp_idx == IDX_W'(BATCH - 1)) begin
                        wr    <= 1'b1;
                        state <= UPD;
                    end else begin
                        smp_idx <= smp_idx + IDX_W'(1);
                        smp_req <= 1'b1;
                        state   <= FETCH;
                    end
                end
                UPD: begin
                    if (epoch == EP_W'(N_EPOCH - 1)) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        epoch    <= epoch + EP_W'(1);
                        smp_idx  <= '0;
                        rst_btch <= 1'b1;
                        state    <= CLR;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_train_ctrl.sv
// Scoreboard bench for train_ctrl: a sample-source model pushes expected array
// inputs and batch costs; a monitor pops them when the DUT strobes load / wr.
module tb_train_ctrl;

    localparam int unsigned N_IN     = 2;
    localparam int unsigned N_OUT    = 2;
    localparam int unsigned WIDTH    = 32;
    localparam int unsigned BATCH    = 2;
    localparam int unsigned N_EPOCH  = 3;
    localparam int unsigned PIPE_LAT = 4;
    localparam int unsigned IDX_W    = 1;
    localparam int unsigned EP_W     = 2;
    localparam int unsigned KW       = N_IN * WIDTH;
    localparam int unsigned TW       = N_OUT * WIDTH;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             busy, done, smp_req, smp_vld;
    logic [IDX_W-1:0] smp_idx;
    logic [KW-1:0]    smp_k, o_k;
    logic [TW-1:0]    smp_t, o_t;
    logic             load, accu, rst_btch, wr;
    logic [WIDTH-1:0] i_cost, cost_sum;
    logic [EP_W-1:0]  epoch;

    int checks = 0;
    int errors = 0;

    logic [KW-1:0]    exp_k_q[$];
    logic [TW-1:0]    exp_t_q[$];
    logic [WIDTH-1:0] exp_cost_q[$];
    logic [WIDTH-1:0] cost_tab[BATCH];
    int               vld_delay = 0;
    bit               noise_en  = 1'b0;
    int               smp_n     = 0;
    logic [WIDTH-1:0] model_sum = '0;
    logic [KW-1:0]    last_k    = '0;
    int               wr_cnt = 0, rb_cnt = 0, load_cnt = 0, accu_cnt = 0;
    int               exp_epoch = 0;
    int               bload = 0;

    always #5 clk = ~clk;

    train_ctrl #(
        .N_IN(N_IN), .N_OUT(N_OUT), .WIDTH(WIDTH), .BATCH(BATCH),
        .N_EPOCH(N_EPOCH), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .smp_req(smp_req), .smp_idx(smp_idx), .smp_vld(smp_vld),
        .smp_k(smp_k), .smp_t(smp_t), .o_k(o_k), .o_t(o_t),
        .load(load), .accu(accu), .rst_btch(rst_btch), .wr(wr),
        .i_cost(i_cost), .epoch(epoch), .cost_sum(cost_sum)
    );

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return s[31:0];
    endfunction

    // Sample source: answers smp_req after vld_delay cycles and records what the array must see.
    initial begin
        int dly;
        int idx;
        dly = 0;
        smp_vld = 1'b0;
        smp_k = '0;
        smp_t = '0;
        i_cost = '0;
        forever begin
            @(negedge clk);
            if (rst_n && smp_req) begin
                idx = smp_n % BATCH;
                checks++;
                if (smp_idx !== IDX_W'(idx)) begin
                    errors++;
                    $display("FAIL smp_idx: got %0d want %0d", smp_idx, idx);
                end
                if (dly < vld_delay) begin
                    dly++;
                    smp_vld = 1'b0;
                    smp_k = {$urandom, $urandom};
                end else begin
                    smp_vld = 1'b1;
                    smp_k = {$urandom, $urandom};
                    smp_t = {$urandom, $urandom};
                    exp_k_q.push_back(smp_k);
                    exp_t_q.push_back(smp_t);
                    i_cost = cost_tab[idx];
                    model_sum = sat_add((idx == 0) ? 32'h0 : model_sum, cost_tab[idx]);
                    if (idx == BATCH - 1) exp_cost_q.push_back(model_sum);
                    smp_n++;
                    dly = 0;
                end
            end else begin
                dly = 0;
                smp_vld = noise_en ? 1'($urandom % 2) : 1'b0;
                if (noise_en) begin
                    smp_k = {$urandom, $urandom};
                    smp_t = {$urandom, $urandom};
                end
            end
        end
    end

    // Monitor: strobe exclusivity/width, and scoreboard pops on load and wr.
    logic [3:0] prev_s = '0;
    always @(negedge clk) begin
        logic [3:0] s;
        logic [KW-1:0] ek;
        logic [TW-1:0] et;
        logic [WIDTH-1:0] ec;
        s = {wr, accu, load, rst_btch};
        if (rst_n) begin
            if (s != 4'b0) begin
                checks++;
                if ($countones(s) > 1 || (s & prev_s) != 4'b0) begin
                    errors++;
                    $display("FAIL strobe_excl: got %b prev %b want one-hot single cycle", s, prev_s);
                end
            end
            if (rst_btch) begin
                rb_cnt++;
                bload = 0;
            end
            if (load) begin
                load_cnt++;
                checks++;
                if (exp_k_q.size() == 0) begin
                    errors++;
                    $display("FAIL load_data: load with no sample delivered");
                end else begin
                    ek = exp_k_q.pop_front();
                    et = exp_t_q.pop_front();
                    last_k = ek;
                    if (o_k !== ek || o_t !== et) begin
                        errors++;
                        $display("FAIL load_data: o_k %h o_t %h want %h %h", o_k, o_t, ek, et);
                    end
                end
                if (bload == 0) begin
                    checks++;
                    if (cost_sum !== '0) begin
                        errors++;
                        $display("FAIL clr_cost: cost_sum %h want 0", cost_sum);
                    end
                end
                bload++;
            end
            if (accu) begin
                accu_cnt++;
                checks++;
                if (o_k !== last_k) begin
                    errors++;
                    $display("FAIL o_k_hold: o_k %h want %h", o_k, last_k);
                end
            end
            if (wr) begin
                wr_cnt++;
                checks++;
                if (exp_cost_q.size() == 0) begin
                    errors++;
                    $display("FAIL batch_cost: wr with no completed batch");
                end else begin
                    ec = exp_cost_q.pop_front();
                    if (cost_sum !== ec || epoch !== EP_W'(exp_epoch)) begin
                        errors++;
                        $display("FAIL batch_cost: cost_sum %h epoch %0d want %h %0d",
                                 cost_sum, epoch, ec, exp_epoch);
                    end
                end
                exp_epoch++;
            end
        end
        prev_s = s;
    end

    // One full run with per-cycle strobe trace compared against a bench-built expected sequence.
    task automatic run_check(input bit poke_start);
        logic [4:0] trace_q[$];
        logic [4:0] got, want;
        int f, total;
        f = 1 + vld_delay;
        total = 1 + N_EPOCH * (2 + BATCH * (f + 2 + PIPE_LAT));
        for (int e = 0; e < N_EPOCH; e++) begin
            trace_q.push_back(5'b00001);
            for (int b = 0; b < BATCH; b++) begin
                for (int i = 0; i < f; i++) trace_q.push_back(5'b10000);
                trace_q.push_back(5'b00010);
                for (int i = 0; i < PIPE_LAT; i++) trace_q.push_back(5'b00000);
                trace_q.push_back(5'b00100);
            end
            trace_q.push_back(5'b01000);
        end
        smp_n = 0;
        exp_epoch = 0;
        wr_cnt = 0;
        rb_cnt = 0;
        start = 1'b1;
        for (int cyc = 1; cyc <= total; cyc++) begin
            @(negedge clk);
            start = poke_start && (cyc % 7 == 3) && (cyc < total);
            got = {smp_req, wr, accu, load, rst_btch};
            want = (cyc < total) ? trace_q.pop_front() : 5'b00000;
            checks++;
            if (got !== want || done !== (cyc == total) || busy !== 1'b1) begin
                errors++;
                $display("FAIL trace cyc %0d: req/wr/accu/load/rb %b done %b busy %b want %b done %b busy 1",
                         cyc, got, done, busy, want, cyc == total);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || cost_sum !== model_sum ||
            epoch !== EP_W'(N_EPOCH - 1) || wr_cnt != N_EPOCH || rb_cnt != N_EPOCH) begin
            errors++;
            $display("FAIL run_end: busy %b done %b cost %h epoch %0d wr %0d rb %0d want 0 0 %h %0d %0d %0d",
                     busy, done, cost_sum, epoch, wr_cnt, rb_cnt, model_sum, N_EPOCH - 1,
                     N_EPOCH, N_EPOCH);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (cost_sum !== model_sum || epoch !== EP_W'(N_EPOCH - 1) || busy !== 1'b0) begin
            errors++;
            $display("FAIL status_hold: cost %h epoch %0d busy %b want %h %0d 0",
                     cost_sum, epoch, busy, model_sum, N_EPOCH - 1);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, smp_req, load, accu, rst_btch, wr} !== 7'b0 || smp_idx !== '0 ||
            epoch !== '0 || cost_sum !== '0 || o_k !== '0 || o_t !== '0) begin
            errors++;
            $display("FAIL reset_state: ctl %b idx %0d epoch %0d cost %h want all zero",
                     {busy, done, smp_req, load, accu, rst_btch, wr}, smp_idx, epoch, cost_sum);
        end
    endtask

    task automatic test_basic_run();
        for (int i = 0; i < BATCH; i++) cost_tab[i] = 32'h0001_0000;
        vld_delay = 0;
        run_check(1'b1);
        checks++;
        if (cost_sum !== 32'h0002_0000) begin
            errors++;
            $display("FAIL basic_cost: got %h want 00020000", cost_sum);
        end
    endtask

    task automatic test_delayed_vld();
        cost_tab[0] = 32'h0000_1234;
        cost_tab[1] = 32'hFFFF_FFFB;
        vld_delay = 5;
        run_check(1'b0);
        vld_delay = 0;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < BATCH; i++) cost_tab[i] = 32'h7FFF_FFF0;
        run_check(1'b0);
        checks++;
        if (cost_sum !== 32'h7FFF_FFFF) begin
            errors++;
            $display("FAIL sat_pos: got %h want 7fffffff", cost_sum);
        end
        for (int i = 0; i < BATCH; i++) cost_tab[i] = 32'h8000_0001;
        run_check(1'b0);
        checks++;
        if (cost_sum !== 32'h8000_0000) begin
            errors++;
            $display("FAIL sat_neg: got %h want 80000000", cost_sum);
        end
    endtask

    task automatic test_noise_vld();
        cost_tab[0] = 32'h0000_0010;
        cost_tab[1] = 32'h0000_0020;
        noise_en = 1'b1;
        run_check(1'b0);
        noise_en = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int lb, a0, w0, t;
        cost_tab[0] = 32'h0000_0100;
        cost_tab[1] = 32'h0000_0200;
        smp_n = 0;
        exp_epoch = 0;
        lb = load_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (load_cnt < lb + 2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 200) begin
            errors++;
            $display("FAIL abort_setup: second load not seen, loads %0d want %0d", load_cnt - lb, 2);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, smp_req, load, accu, rst_btch, wr} !== 7'b0 || smp_idx !== '0 ||
            epoch !== '0 || cost_sum !== '0 || o_k !== '0 || o_t !== '0) begin
            errors++;
            $display("FAIL async_reset: ctl %b idx %0d epoch %0d cost %h want all zero",
                     {busy, done, smp_req, load, accu, rst_btch, wr}, smp_idx, epoch, cost_sum);
        end
        a0 = accu_cnt;
        w0 = wr_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (accu_cnt != a0 || wr_cnt != w0 || busy !== 1'b0 || smp_req !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: accu %0d wr %0d busy %b req %b want %0d %0d 0 0",
                     accu_cnt, wr_cnt, busy, smp_req, a0, w0);
        end
        exp_k_q.delete();
        exp_t_q.delete();
        exp_cost_q.delete();
        run_check(1'b0);
    endtask

    task automatic test_back_to_back();
        cost_tab[0] = 32'hFFFF_0000;
        cost_tab[1] = 32'h0000_0003;
        run_check(1'b1);
        cost_tab[0] = 32'h0000_0007;
        run_check(1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < BATCH; i++) cost_tab[i] = '0;
        test_reset();
        test_basic_run();
        test_delayed_vld();
        test_saturation();
        test_noise_vld();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
